// File: rtl/aud_i2c_slave.sv
// aud_i2c_slave: write-only I2C target for WM8731-style 3-byte control writes.
// Frame: START, {DEV_ADDR,W}, {reg_addr[6:0],data[8]}, data[7:0], STOP.
// SCL/SDA are oversampled on CLOCK_50 through a 2-flop synchronizer and a
// FILT_LEN-sample run-length filter; all bus events come from filtered levels.
// Optional feature: define AUD_I2C_SLAVE_REGFILE_EN to add a 16x9 shadow
// register file with a registered read port (rd_addr/rd_data).
module aud_i2c_slave #(
   parameter logic [6:0] DEV_ADDR = 7'h1A,
   parameter int         FILT_LEN = 3
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       I2C_SCLK,
   inout  wire        I2C_SDAT,
   output logic       wr_valid,
   output logic [6:0] wr_addr,
   output logic [8:0] wr_data,
   output logic       busy,
   output logic       err
`ifdef AUD_I2C_SLAVE_REGFILE_EN
   ,
   input  logic [3:0] rd_addr,
   output logic [8:0] rd_data
`endif
);

   // filter counter only has to reach FILT_LEN-1
   localparam int               FCW      = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN);
   localparam logic [FCW-1:0]   FCNT_MAX = FCW'(FILT_LEN - 1);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_ADDR      = 3'd1;
   localparam logic [2:0] S_ACK_A     = 3'd2;
   localparam logic [2:0] S_BYTE1     = 3'd3;
   localparam logic [2:0] S_ACK_1     = 3'd4;
   localparam logic [2:0] S_BYTE2     = 3'd5;
   localparam logic [2:0] S_ACK_2     = 3'd6;
   localparam logic [2:0] S_WAIT_STOP = 3'd7;

   // bit 0 = SCL, bit 1 = SDA
   logic [1:0]          sync1, sync2, filt, filt_q;
   logic [1:0][FCW-1:0] fcnt;
   logic                sda_pin;

   logic       scl_rise, scl_fall, start_det, stop_det;
   logic       in_ack;
   logic [2:0] state;
   logic [2:0] bit_cnt;
   logic       byte_done;
   logic [7:0] shreg;
   logic [6:0] reg_addr;
   logic       data8;
   logic       rf_err;

   assign sda_pin = I2C_SDAT;

   // open-drain: only ever pull low, and only while acknowledging
   assign in_ack   = (state == S_ACK_A) || (state == S_ACK_1) || (state == S_ACK_2);
   assign I2C_SDAT = in_ack ? 1'b0 : 1'bz;
   assign busy     = (state != S_IDLE);

   // synchronize both lines, then change a filtered level only after a run
   // of FILT_LEN consecutive samples disagreeing with it
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         sync1  <= 2'b11;
         sync2  <= 2'b11;
         filt   <= 2'b11;
         filt_q <= 2'b11;
         fcnt   <= '0;
      end else begin
         sync1  <= {sda_pin, I2C_SCLK};
         sync2  <= sync1;
         filt_q <= filt;
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] == filt[i]) begin
               fcnt[i] <= '0;
            end else if (fcnt[i] == FCNT_MAX) begin
               filt[i] <= sync2[i];
               fcnt[i] <= '0;
            end else begin
               fcnt[i] <= fcnt[i] + 1'b1;
            end
         end
      end
   end

   // START/STOP need SCL steady high across the SDA transition
   assign scl_rise  =  filt[0] & ~filt_q[0];
   assign scl_fall  = ~filt[0] &  filt_q[0];
   assign start_det =  filt[0] &  filt_q[0] &  filt_q[1] & ~filt[1];
   assign stop_det  =  filt[0] &  filt_q[0] & ~filt_q[1] &  filt[1];

   // protocol FSM: sample bits on SCL rise, act on the SCL fall ending a byte
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state     <= S_IDLE;
         bit_cnt   <= 3'd0;
         byte_done <= 1'b0;
         shreg     <= 8'h00;
         reg_addr  <= 7'h00;
         data8     <= 1'b0;
         wr_valid  <= 1'b0;
         wr_addr   <= 7'h00;
         wr_data   <= 9'h000;
         err       <= 1'b0;
      end else begin
         wr_valid <= 1'b0;
         if (rf_err)
            err <= 1'b1;

         if (start_det) begin
            // START or repeated START: always restart address phase
            state     <= S_ADDR;
            bit_cnt   <= 3'd0;
            byte_done <= 1'b0;
            shreg     <= 8'h00;
         end else if (stop_det) begin
            if (state != S_IDLE) begin
               // a STOP inside a partially received frame loses the write
               if (((state == S_ADDR) && (bit_cnt != 3'd0)) ||
                   (state == S_BYTE1) || (state == S_BYTE2))
                  err <= 1'b1;
               state     <= S_IDLE;
               bit_cnt   <= 3'd0;
               byte_done <= 1'b0;
            end
         end else begin
            case (state)
               S_ADDR, S_BYTE1, S_BYTE2, S_WAIT_STOP: begin
                  if (scl_rise) begin
                     shreg   <= {shreg[6:0], filt[1]};
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7)
                        byte_done <= 1'b1;
                  end else if (scl_fall && byte_done) begin
                     byte_done <= 1'b0;
                     case (state)
                        S_ADDR: begin
                           // address match includes R/W=0; reads are not served
                           if (shreg == {DEV_ADDR, 1'b0})
                              state <= S_ACK_A;
                           else
                              state <= S_IDLE;
                        end
                        S_BYTE1: begin
                           reg_addr <= shreg[7:1];
                           data8    <= shreg[0];
                           state    <= S_ACK_1;
                        end
                        S_BYTE2: begin
                           wr_addr  <= reg_addr;
                           wr_data  <= {data8, shreg};
                           wr_valid <= 1'b1;
                           state    <= S_ACK_2;
                        end
                        default: begin
                           // extra byte after a complete write: NACK and flag
                           err <= 1'b1;
                        end
                     endcase
                  end
               end
               S_ACK_A, S_ACK_1, S_ACK_2: begin
                  // hold SDA low through the ACK clock, release on its fall
                  if (scl_fall) begin
                     bit_cnt   <= 3'd0;
                     byte_done <= 1'b0;
                     case (state)
                        S_ACK_A: state <= S_BYTE1;
                        S_ACK_1: state <= S_BYTE2;
                        default: state <= S_WAIT_STOP;
                     endcase
                  end
               end
               default: begin
                  bit_cnt   <= 3'd0;
                  byte_done <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef AUD_I2C_SLAVE_REGFILE_EN
   logic [15:0][8:0] regs;

   // only addresses 0..15 exist in the shadow file
   assign rf_err = wr_valid && (wr_addr[6:4] != 3'd0);

   // shadow register file; register 0x0F is the codec reset and clears all
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         regs    <= '0;
         rd_data <= 9'h000;
      end else begin
         if (wr_valid && (wr_addr[6:4] == 3'd0)) begin
            if (wr_addr[3:0] == 4'hF)
               regs <= '0;
            else
               regs[wr_addr[3:0]] <= wr_data;
         end
         rd_data <= regs[rd_addr];
      end
   end
`else
   assign rf_err = 1'b0;
`endif

endmodule

// File: tb/tb_aud_i2c_slave.sv
// tb_aud_i2c_slave: bit-banged I2C initiator around aud_i2c_slave.
// Expected writes go into a scoreboard queue when a frame is sent; a monitor
// pops and compares on every wr_valid strobe.
module tb_aud_i2c_slave;

   typedef struct {
      logic [6:0] a;
      logic [8:0] d;
   } wr_t;

   logic       CLOCK_50   = 1'b0;
   logic       reset      = 1'b1;
   logic       scl        = 1'b1;
   logic       tb_sda_low = 1'b0;
   wire        sda;
   logic       wr_valid;
   logic [6:0] wr_addr;
   logic [8:0] wr_data;
   logic       busy, err;
`ifdef AUD_I2C_SLAVE_REGFILE_EN
   logic [3:0] rd_addr = 4'h0;
   logic [8:0] rd_data;
`endif

   int   n_chk  = 0;
   int   n_pass = 0;
   int   n_pull = 0;
   int   n_wr   = 0;
   int   n0     = 0;
   logic prev_wv = 1'b0;
   wr_t  exp_q[$];
   wr_t  e;

   pullup (sda);
   assign sda = tb_sda_low ? 1'b0 : 1'bz;

   always #10 CLOCK_50 = ~CLOCK_50;

   aud_i2c_slave #(.DEV_ADDR(7'h1A), .FILT_LEN(3)) dut (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .I2C_SCLK (scl),
      .I2C_SDAT (sda),
      .wr_valid (wr_valid),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .busy     (busy),
      .err      (err)
`ifdef AUD_I2C_SLAVE_REGFILE_EN
      ,
      .rd_addr  (rd_addr),
      .rd_data  (rd_data)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge CLOCK_50);
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      wait_cyc(3);
      reset = 1'b0;
      wait_cyc(2);
   endtask

   task automatic i2c_start(input int hp);
      tb_sda_low = 1'b0;
      wait_cyc(hp/2);
      scl = 1'b1;
      wait_cyc(hp);
      tb_sda_low = 1'b1;
      wait_cyc(hp);
      scl = 1'b0;
   endtask

   task automatic i2c_stop(input int hp);
      wait_cyc(hp/2);
      tb_sda_low = 1'b1;
      wait_cyc(hp/2);
      scl = 1'b1;
      wait_cyc(hp);
      tb_sda_low = 1'b0;
      wait_cyc(hp);
   endtask

   // MSB-first bits; SDA moves mid-low, optional 1-cycle SCL glitch on bit 'glitch'
   task automatic send_bits(input logic [7:0] b, input int nbits, input int hp, input int glitch);
      for (int i = 7; i > 7 - nbits; i--) begin
         wait_cyc(hp/2);
         tb_sda_low = ~b[i];
         if (i == glitch) begin
            wait_cyc(2);
            scl = 1'b1;
            wait_cyc(1);
            scl = 1'b0;
            wait_cyc(hp/2 - 3);
         end else begin
            wait_cyc(hp/2);
         end
         scl = 1'b1;
         wait_cyc(hp);
         scl = 1'b0;
      end
   endtask

   task automatic send_byte(input string tag, input logic [7:0] b, input int hp,
                            input int glitch, input logic exp_ack);
      logic ack;
      send_bits(b, 8, hp, glitch);
      wait_cyc(hp/2);
      tb_sda_low = 1'b0;
      wait_cyc(hp/2);
      scl = 1'b1;
      wait_cyc(hp/2);
      ack = sda;
      wait_cyc(hp/2);
      scl = 1'b0;
      chk(tag, ack, exp_ack);
   endtask

   task automatic do_write(input string tag, input logic [7:0] a, input logic [7:0] b1,
                           input logic [7:0] b2, input int hp, input int glitch,
                           input logic exp_ack);
      i2c_start(hp);
      send_byte({tag, "_ack0"}, a,  hp, -1,     exp_ack);
      send_byte({tag, "_ack1"}, b1, hp, glitch, exp_ack);
      send_byte({tag, "_ack2"}, b2, hp, -1,     exp_ack);
      i2c_stop(hp);
      wait_cyc(10);
   endtask

   // scoreboard monitor and DUT pull-down detector, sampled mid-cycle
   always @(posedge CLOCK_50) begin
      #5;
      if (!reset) begin
         if (!tb_sda_low && sda === 1'b0) n_pull++;
         if (wr_valid) begin
            n_wr++;
            chk("wr_one_cycle", prev_wv, 1'b0);
            chk("wr_expected", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("wr_addr", wr_addr, e.a);
               chk("wr_data", wr_data, e.d);
            end
         end
      end
      prev_wv = wr_valid;
   end

   initial begin
      #1800000;
      $display("FAIL watchdog: time limit reached, %0d/%0d checks passed so far", n_pass, n_chk);
      $fatal(1, "watchdog");
   end

   initial begin
      wait_cyc(4);
      reset = 1'b0;
      wait_cyc(2);
      chk("rst_wr_valid", wr_valid, 1'b0);
      chk("rst_wr_addr",  wr_addr,  7'h00);
      chk("rst_wr_data",  wr_data,  9'h000);
      chk("rst_busy",     busy,     1'b0);
      chk("rst_err",      err,      1'b0);
      chk("rst_sda",      sda,      1'b1);

      // nominal write at 100 kHz SCL
      exp_q.push_back(wr_t'{7'h02, 9'h179});
      n0 = n_wr;
      i2c_start(250);
      chk("t1_busy", busy, 1'b1);
      send_byte("t1_ack0", 8'h34, 250, -1, 1'b0);
      send_byte("t1_ack1", 8'h05, 250, -1, 1'b0);
      send_byte("t1_ack2", 8'h79, 250, -1, 1'b0);
      i2c_stop(250);
      wait_cyc(10);
      chk("t1_wr_count", n_wr - n0, 1);
      chk("t1_err",      err, 1'b0);
      chk("t1_busy_end", busy, 1'b0);
      chk("t1_hold",     {wr_addr, wr_data}, {7'h02, 9'h179});

      // wrong device address: never acknowledged, no write, no error
      n0 = n_wr;
      begin
         int p0;
         p0 = n_pull;
         do_write("t2", 8'h36, 8'h05, 8'h79, 25, -1, 1'b1);
         chk("t2_no_pull", n_pull - p0, 0);
      end
      chk("t2_wr_count", n_wr - n0, 0);
      chk("t2_err",      err,  1'b0);
      chk("t2_busy",     busy, 1'b0);

      // STOP after 4 bits of byte 2: dropped and flagged, then a good write
      n0 = n_wr;
      i2c_start(25);
      send_byte("t3_ack0", 8'h34, 25, -1, 1'b0);
      send_byte("t3_ack1", 8'h0C, 25, -1, 1'b0);
      send_bits(8'h79, 4, 25, -1);
      i2c_stop(25);
      wait_cyc(10);
      chk("t3_wr_count", n_wr - n0, 0);
      chk("t3_err",      err,  1'b1);
      chk("t3_busy",     busy, 1'b0);
      exp_q.push_back(wr_t'{7'h02, 9'h179});
      do_write("t3b", 8'h34, 8'h05, 8'h79, 25, -1, 1'b0);
      chk("t3b_wr_count", n_wr - n0, 1);
      chk("t3b_err_sticky", err, 1'b1);
      pulse_reset();
      chk("t3_err_cleared", err, 1'b0);

      // repeated START discards the partial frame
      n0 = n_wr;
      exp_q.push_back(wr_t'{7'h09, 9'h00C});
      i2c_start(25);
      send_byte("t4_ack0", 8'h34, 25, -1, 1'b0);
      send_byte("t4_ack1", 8'h0E, 25, -1, 1'b0);
      do_write("t4b", 8'h34, 8'h12, 8'h0C, 25, -1, 1'b0);
      chk("t4_wr_count", n_wr - n0, 1);
      chk("t4_err",      err, 1'b0);

      // 1-cycle SCL glitch during byte 1 is filtered out
      n0 = n_wr;
      exp_q.push_back(wr_t'{7'h02, 9'h179});
      do_write("t5", 8'h34, 8'h05, 8'h79, 25, 5, 1'b0);
      chk("t5_wr_count", n_wr - n0, 1);
      chk("t5_err",      err, 1'b0);

      // extra byte after a complete write is NACKed and flagged
      n0 = n_wr;
      exp_q.push_back(wr_t'{7'h3F, 9'h1AA});
      i2c_start(25);
      send_byte("t6_ack0", 8'h34, 25, -1, 1'b0);
      send_byte("t6_ack1", 8'h7F, 25, -1, 1'b0);
      send_byte("t6_ack2", 8'hAA, 25, -1, 1'b0);
      send_byte("t6_nack", 8'h55, 25, -1, 1'b1);
      i2c_stop(25);
      wait_cyc(10);
      chk("t6_wr_count", n_wr - n0, 1);
      chk("t6_err",      err,  1'b1);
      chk("t6_busy",     busy, 1'b0);

`ifdef AUD_I2C_SLAVE_REGFILE_EN
      pulse_reset();
      exp_q.push_back(wr_t'{7'h04, 9'h015});
      do_write("rf_w4", 8'h34, 8'h08, 8'h15, 25, -1, 1'b0);
      rd_addr = 4'h4;
      wait_cyc(1);
      chk("rf_rd4", rd_data, 9'h015);
      exp_q.push_back(wr_t'{7'h0F, 9'h000});
      do_write("rf_clr", 8'h34, 8'h1E, 8'h00, 25, -1, 1'b0);
      chk("rf_rd4_clr",   rd_data, 9'h000);
      chk("rf_err_clean", err, 1'b0);
      exp_q.push_back(wr_t'{7'h10, 9'h000});
      do_write("rf_oob", 8'h34, 8'h20, 8'h00, 25, -1, 1'b0);
      chk("rf_err_oob", err, 1'b1);
`endif

      // reset during the address ACK releases SDA right after it is sampled
      i2c_start(25);
      send_bits(8'h34, 8, 25, -1);
      wait_cyc(12);
      tb_sda_low = 1'b0;
      for (int k = 0; k < 20 && sda !== 1'b0; k++) wait_cyc(1);
      chk("t7_ack_drive", sda, 1'b0);
      reset = 1'b1;
      @(posedge CLOCK_50);
      #5;
      chk("t7_sda_rel",  sda,  1'b1);
      chk("t7_busy_rst", busy, 1'b0);
      chk("t7_err_rst",  err,  1'b0);
      @(negedge CLOCK_50);
      reset = 1'b0;
      scl   = 1'b1;
      wait_cyc(20);
      chk("t7_busy_idle", busy, 1'b0);
      n0 = n_wr;
      exp_q.push_back(wr_t'{7'h02, 9'h179});
      do_write("t7b", 8'h34, 8'h05, 8'h79, 25, -1, 1'b0);
      chk("t7b_wr_count", n_wr - n0, 1);

      chk("sb_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/aud_i2c_slave.md
Name: aud_i2c_slave

Overview:
- I2C write-only target that receives WM8731-style 3-byte control writes: device address, then {reg_addr[6:0], data[8]}, then data[7:0].
- It is the responder end of the codec control bus, oversampling SCL/SDA on CLOCK_50.
- Serves as an on-chip codec control model for board-level loopback and simulation.
- Each accepted write is presented as a one-cycle strobe with a 7-bit register address and 9-bit data.

Parameters:
- DEV_ADDR, 7'h1A: 7-bit target address; write address byte is 8'h34.
- FILT_LEN, 3: consecutive equal samples required before a filtered SCL/SDA level changes.

Ports:
- CLOCK_50  input  1  50 MHz system clock.
- reset  input  1  synchronous, active-high reset.
- I2C_SCLK  input  1  bus clock from initiator.
- I2C_SDAT  inout  1  bus data, open-drain: driven 0 or 'z', never 1.
- wr_valid  output  1  one-cycle strobe: write accepted.
- wr_addr  output  7  register address of last accepted write.
- wr_data  output  9  data of last accepted write.
- busy  output  1  high from START detect until STOP or abort to IDLE.
- err  output  1  sticky; set on protocol error, cleared only by reset.

Behaviour:
- Input path: SCL and SDA each pass a 2-flop synchronizer, then a FILT_LEN-sample filter. All edge detection uses filtered levels of the current vs previous cycle.
- START: filtered SDA falls while filtered SCL is high. STOP: filtered SDA rises while filtered SCL high.
- Data bits are sampled MSB-first on filtered SCL rising edges. A 3-bit bit counter counts 0..7.
- States: IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, WAIT_STOP.
- IDLE -> ADDR on START. START in any state (repeated START) -> ADDR with bit counter cleared and partial data discarded.
- ADDR: after 8 bits, check {DEV_ADDR,1'b0} match.
  - Match: ACK_A.
  - Mismatch, or R/W=1: no ACK, -> IDLE (err not set).
- ACK_A, ACK_1, ACK_2 ACK timing:
  - Drive SDA low starting at the SCL falling edge that ends bit 7.
  - Release SDA at the next SCL falling edge.
  - Then go to BYTE1, BYTE2 or WAIT_STOP respectively.
- BYTE1 latches addr/data[8]; BYTE2 latches data[7:0].
- At the SCL falling edge ending BYTE2 bit 7 (entry to ACK_2):
  - wr_addr and wr_data update.
  - wr_valid is high for exactly that one cycle.
- WAIT_STOP: extra bytes are NACKed (SDA released) and err is set. STOP -> IDLE.
- STOP in ADDR/BYTE1/BYTE2 with bit counter nonzero, or in BYTE1/BYTE2 before the byte completes: discard, err set, -> IDLE, no wr_valid.
- STOP in IDLE is ignored.
- SDA release is guaranteed within 1 cycle of any state leaving an ACK state; SDA is never driven in IDLE.
- Reset (any time, including mid-ACK): state IDLE, SDA released, wr_valid 0, wr_addr 0, wr_data 0, busy 0, err 0, filters preset to 1 (bus idle), counters 0.
- Latency from pin edge to detected edge: 2 + FILT_LEN cycles.

Optional Feature:
- Macro: AUD_I2C_SLAVE_REGFILE_EN.
- Defined:
  - Adds ports rd_addr (input, 4) and rd_data (output, 9).
  - Adds an internal 16x9 shadow register file, reset to 0.
  - On wr_valid with wr_addr < 16, entry wr_addr is written. Writes with wr_addr >= 16 are dropped and set err.
  - wr_addr 7'h0F (reset register) clears all 16 entries instead of storing data.
  - rd_data is registered: rd_data = regfile[rd_addr] one cycle after rd_addr.
- Undefined: these ports and the storage are absent; wr_* behaviour is unchanged.

Test Plan:
- START, 0x34, 0x05, 0x79, STOP at 100 kHz SCL:
  - three ACKs seen on SDA;
  - one wr_valid with wr_addr=7'h02, wr_data=9'h179;
  - err=0.
- START, 0x36 (wrong address), 0x05, 0x79, STOP: SDA never driven low, no wr_valid, err=0, busy low after STOP.
- START, 0x34, 0x0C, then STOP after 4 bits of byte 2: no wr_valid, err=1; a following valid write still produces wr_valid.
- START, 0x34, 0x0E, repeated START, 0x34, 0x12, 0x0C, STOP: exactly one wr_valid with wr_addr=7'h09, wr_data=9'h00C.
- Single-cycle 20 ns glitch on SCL during byte 1 with FILT_LEN=3: no extra bit counted, write decodes correctly.
- REGFILE_EN: write addr 7'h04 data 9'h015, then rd_addr=4 -> rd_data=9'h015 next cycle; write addr 7'h0F -> rd_data=0; reset asserted mid-ACK -> SDA released the same cycle reset is sampled.
